// File: rtl/c1541_step_seq.sv
// c1541_step_seq: drive-side stepper sequencer that walks the head to a target half-track.
// Optional recalibrate (80 forced decrement steps) is enabled by defining C1541_STEP_RECAL_EN.
`default_nettype none

module c1541_step_seq #(
  parameter int STEP_CYCLES     = 6000,
  parameter int SETTLE_CYCLES   = 15000,
  parameter int SPINUP_CYCLES   = 20000,
  parameter int MTR_IDLE_CYCLES = 200000
) (
  input  logic       clk_c1541,
  input  logic       reset,
  input  logic       ce,
  input  logic       seek_req,
  input  logic [6:0] seek_ht,
`ifdef C1541_STEP_RECAL_EN
  input  logic       recal_req,
`endif
  output logic       seek_ack,
  output logic       busy,
  output logic       done,
  output logic [6:0] cur_ht,
  output logic [1:0] stp,
  output logic       mtr
);

  localparam logic [31:0] STEP_LAST  = 32'((STEP_CYCLES > 0) ? STEP_CYCLES - 1 : 0);
  localparam logic [31:0] SPIN_LAST  = 32'((SPINUP_CYCLES > 0) ? SPINUP_CYCLES - 1 : 0);
  localparam logic [31:0] SETTLE_END = 32'(SETTLE_CYCLES);
  localparam logic [31:0] IDLE_LAST  = 32'((MTR_IDLE_CYCLES > 0) ? MTR_IDLE_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SPINUP = 3'd1,
    S_STEP   = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [31:0] cnt, cnt_nx;
  logic [31:0] idle_cnt, idle_nx;
  logic [6:0]  tgt, tgt_nx;
  logic [6:0]  ht_nx;
  logic [1:0]  stp_nx;
  logic        mtr_nx, busy_nx, ack_nx, done_nx;

  logic [6:0]  tgt_req, tgt_sel, ht_step, ht_after;
  logic [1:0]  stp_step;
  logic        go_down, more, start, start_step, is_recal;

`ifdef C1541_STEP_RECAL_EN
  logic        recal, recal_nx;
  logic [6:0]  rem, rem_nx;
  assign is_recal = recal;
`else
  assign is_recal = 1'b0;
`endif

  // Phase wheel: increment walks 0,2,1,3; decrement walks the same ring backwards.
  function automatic logic [1:0] inc_ph(input logic [1:0] p);
    case (p)
      2'd0:    inc_ph = 2'd2;
      2'd2:    inc_ph = 2'd1;
      2'd1:    inc_ph = 2'd3;
      default: inc_ph = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] dec_ph(input logic [1:0] p);
    case (p)
      2'd0:    dec_ph = 2'd3;
      2'd3:    dec_ph = 2'd1;
      2'd1:    dec_ph = 2'd2;
      default: dec_ph = 2'd0;
    endcase
  endfunction

  always_ff @(posedge clk_c1541) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idle_cnt <= '0;
      tgt      <= 7'd36;
      cur_ht   <= 7'd36;
      stp      <= 2'd0;
      mtr      <= 1'b0;
      busy     <= 1'b0;
      seek_ack <= 1'b0;
      done     <= 1'b0;
`ifdef C1541_STEP_RECAL_EN
      recal    <= 1'b0;
      rem      <= '0;
`endif
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      idle_cnt <= idle_nx;
      tgt      <= tgt_nx;
      cur_ht   <= ht_nx;
      stp      <= stp_nx;
      mtr      <= mtr_nx;
      busy     <= busy_nx;
      seek_ack <= ack_nx;
      done     <= done_nx;
`ifdef C1541_STEP_RECAL_EN
      recal    <= recal_nx;
      rem      <= rem_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idle_nx  = idle_cnt;
    tgt_nx   = tgt;
    ht_nx    = cur_ht;
    stp_nx   = stp;
    mtr_nx   = mtr;
    busy_nx  = busy;
    ack_nx   = 1'b0;
    done_nx  = 1'b0;
`ifdef C1541_STEP_RECAL_EN
    recal_nx = recal;
    rem_nx   = rem;
`endif

    tgt_req  = (seek_ht < 7'd1) ? 7'd1 : (seek_ht > 7'd80) ? 7'd80 : seek_ht;
    go_down  = is_recal || (tgt < cur_ht);
    // Saturate at the decoder bounds; recal keeps rotating the phase at the floor.
    ht_step  = go_down ? ((cur_ht > 7'd1) ? cur_ht - 7'd1 : cur_ht)
                       : ((cur_ht < 7'd80) ? cur_ht + 7'd1 : cur_ht);
    stp_step = go_down ? dec_ph(stp) : inc_ph(stp);
    ht_after = (cnt == 32'd0) ? ht_step : cur_ht;
    more     = (ht_after != tgt);
`ifdef C1541_STEP_RECAL_EN
    if (recal) more = (((cnt == 32'd0) ? rem - 7'd1 : rem) != 7'd0);
`endif

    start      = seek_req;
    start_step = (tgt_req != cur_ht);
    tgt_sel    = tgt_req;

    if (ce) begin
      case (state)
        S_IDLE: begin
          if (mtr) begin
            if (idle_cnt >= IDLE_LAST) mtr_nx = 1'b0;
            else idle_nx = idle_cnt + 32'd1;
          end
`ifdef C1541_STEP_RECAL_EN
          if (recal_req) begin
            start      = 1'b1;
            start_step = 1'b1;
            tgt_sel    = 7'd1;
            recal_nx   = 1'b1;
            rem_nx     = 7'd80;
          end
`endif
          if (start) begin
            tgt_nx  = tgt_sel;
            ack_nx  = 1'b1;
            busy_nx = 1'b1;
            mtr_nx  = 1'b1;
            idle_nx = '0;
            cnt_nx  = '0;
            state_nx = !mtr ? S_SPINUP : (start_step ? S_STEP : S_SETTLE);
          end
        end
        S_SPINUP: begin
          if (cnt >= SPIN_LAST) begin
            cnt_nx   = '0;
            state_nx = (is_recal || (tgt != cur_ht)) ? S_STEP : S_SETTLE;
          end else begin
            cnt_nx = cnt + 32'd1;
          end
        end
        S_STEP: begin
          if (cnt == 32'd0) begin
            stp_nx = stp_step;
            ht_nx  = ht_step;
`ifdef C1541_STEP_RECAL_EN
            if (recal) rem_nx = rem - 7'd1;
`endif
          end
          if (cnt >= STEP_LAST) begin
            cnt_nx   = '0;
            state_nx = more ? S_STEP : S_SETTLE;
          end else begin
            cnt_nx = cnt + 32'd1;
          end
        end
        S_SETTLE: begin
          if (cnt >= SETTLE_END) begin
            cnt_nx   = '0;
            state_nx = S_DONE;
          end else begin
            cnt_nx = cnt + 32'd1;
          end
        end
        S_DONE: begin
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          idle_nx  = '0;
          state_nx = S_IDLE;
`ifdef C1541_STEP_RECAL_EN
          recal_nx = 1'b0;
`endif
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
